// File: rtl/ddr3_traffic_gen.sv
// DDR3 traffic generator: a single write-then-readback pass over NUM_BURSTS BL8
// bursts on the MIG native app interface, with beat compare, error count and watchdog.
module ddr3_traffic_gen #(
   parameter int                    ADDR_WIDTH = 30,
   parameter int                    DATA_WIDTH = 512,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    NUM_BURSTS = 256,
   parameter logic [31:0]           SEED       = 32'h0,
   parameter int                    TIMEOUT    = 65535
) (
   input  logic                    sys_clk_i,
   input  logic                    sys_rst_n,
   input  logic                    init_calib_complete,
   input  logic                    app_rdy,
   output logic                    app_en,
   output logic [2:0]              app_cmd,
   output logic [ADDR_WIDTH-1:0]   app_addr,
   input  logic                    app_wdf_rdy,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   output logic [DATA_WIDTH-1:0]   app_wdf_data,
   output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                    app_rd_data_valid,
   input  logic [DATA_WIDTH-1:0]   app_rd_data,
   input  logic                    restart,
   output logic                    tg_compare_error,
   output logic [15:0]             err_count,
   output logic                    timeout,
   output logic                    done
);
   localparam int             CW    = 25;
   localparam int             LANES = DATA_WIDTH / 32;
   localparam logic [CW-1:0]  NB    = CW'(NUM_BURSTS);
   localparam logic [31:0]    TO    = 32'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_DONE} state_t;

   state_t                  r_state, w_state_n;
   logic [CW-1:0]           r_wcmd, r_wdat, r_rcmd, r_rdat;
   logic [CW-1:0]           w_wcmd_n, w_wdat_n, w_rcmd_n, w_rdat_n;
   logic [31:0]             r_wdog, w_wdog_n;
   logic                    r_app_en, r_app_wdf_wren, r_err, r_timeout, r_done;
   logic [2:0]              r_app_cmd;
   logic [ADDR_WIDTH-1:0]   r_app_addr;
   logic [DATA_WIDTH-1:0]   r_app_wdf_data;
   logic [15:0]             r_err_count;
   logic                    w_cmd_hs, w_wd_hs, w_active, w_rd_ok, w_beat, w_spur, w_miscmp;
   logic                    w_progress, w_drop, w_tmo, w_abort;

   function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [23:0] k);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      for (int j = 0; j < LANES; j++) d[j*32 +: 32] = {k, 8'(j)} ^ SEED;
      return d;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [CW-1:0] k);
      return BASE_ADDR + ADDR_WIDTH'({k, 3'b000});
   endfunction

   always_comb begin
      w_cmd_hs   = r_app_en & app_rdy;
      w_wd_hs    = r_app_wdf_wren & app_wdf_rdy;
      w_active   = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_WAIT_RD);
      w_rd_ok    = ((r_state == S_READ) || (r_state == S_WAIT_RD)) && (r_rdat < NB);
      w_beat     = app_rd_data_valid & w_rd_ok;
      w_spur     = app_rd_data_valid & ~w_rd_ok;
      w_miscmp   = w_beat && (app_rd_data != f_pattern(r_rdat[23:0]));
      w_wcmd_n   = r_wcmd + {{(CW-1){1'b0}}, (r_state == S_WRITE) & w_cmd_hs};
      w_wdat_n   = r_wdat + {{(CW-1){1'b0}}, (r_state == S_WRITE) & w_wd_hs};
      w_rcmd_n   = r_rcmd + {{(CW-1){1'b0}}, (r_state == S_READ) & w_cmd_hs};
      w_rdat_n   = r_rdat + {{(CW-1){1'b0}}, w_beat};
      w_progress = w_cmd_hs | w_wd_hs | app_rd_data_valid;
      w_wdog_n   = w_progress ? 32'd0 : r_wdog + 32'd1;
      w_drop     = w_active & ~init_calib_complete;
      w_tmo      = w_active & ~w_drop & ~w_progress & (w_wdog_n >= TO);
      w_abort    = w_drop | w_tmo;

      w_state_n = r_state;
      case (r_state)
         S_IDLE:    if (init_calib_complete) w_state_n = S_WRITE;
         S_WRITE:   if ((r_wcmd == NB) && (r_wdat == NB)) w_state_n = S_READ;
         S_READ:    if (r_rcmd == NB) w_state_n = (w_rdat_n == NB) ? S_DONE : S_WAIT_RD;
         S_WAIT_RD: if (w_rdat_n == NB) w_state_n = S_DONE;
         S_DONE:    if (restart) w_state_n = S_IDLE;
         default:   w_state_n = S_IDLE;
      endcase
      if (w_drop)     w_state_n = S_IDLE;
      else if (w_tmo) w_state_n = S_DONE;
   end

   // Request outputs are built from the post-handshake counters so they hold while stalled.
   always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state        <= S_IDLE;
         r_wcmd         <= '0;
         r_wdat         <= '0;
         r_rcmd         <= '0;
         r_rdat         <= '0;
         r_wdog         <= '0;
         r_app_en       <= 1'b0;
         r_app_cmd      <= 3'b000;
         r_app_addr     <= '0;
         r_app_wdf_wren <= 1'b0;
         r_app_wdf_data <= '0;
         r_err          <= 1'b0;
         r_err_count    <= '0;
         r_timeout      <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_done  <= (w_state_n == S_DONE);
         r_wdog  <= w_active ? w_wdog_n : 32'd0;
         if (w_state_n == S_IDLE) begin
            r_wcmd <= '0;
            r_wdat <= '0;
            r_rcmd <= '0;
            r_rdat <= '0;
         end else begin
            r_wcmd <= w_wcmd_n;
            r_wdat <= w_wdat_n;
            r_rcmd <= w_rcmd_n;
            r_rdat <= w_rdat_n;
         end

         if ((r_state == S_WRITE) && !w_abort) begin
            r_app_en       <= (w_wcmd_n < NB) && (w_wcmd_n < w_wdat_n + CW'(2));
            r_app_cmd      <= 3'b000;
            r_app_addr     <= f_addr(w_wcmd_n);
            r_app_wdf_wren <= (w_wdat_n < NB) && (w_wdat_n <= w_wcmd_n);
            r_app_wdf_data <= f_pattern(w_wdat_n[23:0]);
         end else if ((r_state == S_READ) && !w_abort) begin
            r_app_en       <= (w_rcmd_n < NB);
            r_app_cmd      <= 3'b001;
            r_app_addr     <= f_addr(w_rcmd_n);
            r_app_wdf_wren <= 1'b0;
         end else begin
            r_app_en       <= 1'b0;
            r_app_wdf_wren <= 1'b0;
         end

         if ((r_state == S_DONE) && restart) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_timeout   <= 1'b0;
         end else begin
            if (w_miscmp || w_spur) begin
               r_err <= 1'b1;
               if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
            if (w_tmo) begin
               r_timeout <= 1'b1;
               r_err     <= 1'b1;
            end
         end
      end
   end

   assign app_en           = r_app_en;
   assign app_cmd          = r_app_cmd;
   assign app_addr         = r_app_addr;
   assign app_wdf_wren     = r_app_wdf_wren;
   assign app_wdf_end      = r_app_wdf_wren;
   assign app_wdf_data     = r_app_wdf_data;
   assign app_wdf_mask     = '0;
   assign tg_compare_error = r_err;
   assign err_count        = r_err_count;
   assign timeout          = r_timeout;
   assign done             = r_done;
endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Directed bench for ddr3_traffic_gen: a small MIG-like memory model answers the
// generator, and each scenario is compared against hand-derived results.
module tb_ddr3_traffic_gen;
   localparam int AW = 30, DW = 64, NB = 4, TO = 16;

   logic          clk = 1'b0;
   logic          rst_n, init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, restart;
   logic          app_en, app_wdf_wren, app_wdf_end, tg_compare_error, timeout, done;
   logic [2:0]    app_cmd;
   logic [AW-1:0] app_addr;
   logic [DW-1:0] app_wdf_data, app_rd_data;
   logic [DW/8-1:0] app_wdf_mask;
   logic [15:0]   err_count;

   always #5 clk = ~clk;

   ddr3_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BURSTS(NB),
                      .SEED(32'h0), .TIMEOUT(TO)) u_dut (
      .sys_clk_i(clk), .sys_rst_n(rst_n), .init_calib_complete(init_calib_complete),
      .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
      .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
      .restart(restart), .tg_compare_error(tg_compare_error), .err_count(err_count),
      .timeout(timeout), .done(done));

   int n_chk = 0, n_fail = 0;
   int cyc = 0, cyc_done, cyc_last_beat, cyc_bad, corrupt_k, st1, r0;
   int nw_cmd, nw_dat, nr_cmd, nr_beat;
   int waq[$], rq[$], waddr_log[$];
   logic [DW-1:0] wdq[$];
   logic [DW-1:0] mem [4];
   bit bp, tmo_mode, inj, inj_done, seen_done, wtog;
   bit p_en, p_rdy, p_wren, p_wrdy;
   logic [2:0]    p_cmd;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int k);
      return {24'(k), 8'h01, 24'(k), 8'h00};
   endfunction

   task automatic start_pass();
      waq.delete(); rq.delete(); wdq.delete(); waddr_log.delete();
      for (int i = 0; i < 4; i++) mem[i] = '0;
      nw_cmd = 0; nw_dat = 0; nr_cmd = 0; nr_beat = 0;
      seen_done = 0; cyc_done = -1; cyc_last_beat = -1; cyc_bad = -1; st1 = 0;
   endtask

   // One clock: observe outputs at negedge, then drive the memory model's response.
   task automatic cycle();
      int k;
      logic [DW-1:0] d;
      @(negedge clk);
      cyc++;
      if (done && !seen_done) begin seen_done = 1; cyc_done = cyc; end
      if (cyc_bad >= 0 && cyc == cyc_bad + 1) check("err_cnt_lat", 64'(err_count), 64'd1);
      if (bp) begin
         if (p_en && !p_rdy) check("cmd_hold", 64'({app_en, app_cmd, app_addr}), 64'({1'b1, p_cmd, p_addr}));
         if (p_wren && !p_wrdy) check("wdat_hold", {app_wdf_data[62:0], app_wdf_wren}, {p_data[62:0], 1'b1});
      end
      if (tmo_mode) begin
         app_rdy = 0; app_wdf_rdy = 0;
      end else if (bp) begin
         if (app_en && app_cmd == 3'b000 && app_addr == 30'd8 && st1 < 3) begin app_rdy = 0; st1++; end
         else app_rdy = 1;
         wtog = !wtog; app_wdf_rdy = wtog;
      end else begin
         app_rdy = 1; app_wdf_rdy = 1;
      end
      app_rd_data_valid = 0; app_rd_data = '0;
      if (!init_calib_complete) begin
         rq.delete(); waq.delete(); wdq.delete();
      end else begin
         if (rq.size() > 0) begin
            k = rq.pop_front(); d = mem[k];
            if (k == corrupt_k) begin
               d[0] = ~d[0];
               check("err_cnt_pre", 64'(err_count), 64'd0);
               cyc_bad = cyc;
            end
            app_rd_data_valid = 1; app_rd_data = d; nr_beat++; cyc_last_beat = cyc;
         end else if (inj && !inj_done && app_wdf_wren) begin
            app_rd_data_valid = 1; app_rd_data = 64'hDEAD; inj_done = 1;
         end
         if (app_en && app_rdy) begin
            if (app_cmd == 3'b000) begin
               waq.push_back(int'(app_addr[4:3])); waddr_log.push_back(int'(app_addr)); nw_cmd++;
            end else begin
               rq.push_back(int'(app_addr[4:3])); nr_cmd++;
            end
         end
         if (app_wdf_wren && app_wdf_rdy) begin wdq.push_back(app_wdf_data); nw_dat++; end
         while (waq.size() > 0 && wdq.size() > 0) mem[waq.pop_front()] = wdq.pop_front();
         if (bp) check("lead", 64'(nw_cmd - nw_dat <= 2), 64'd1);
      end
      p_en = app_en; p_rdy = app_rdy; p_cmd = app_cmd; p_addr = app_addr;
      p_wren = app_wdf_wren; p_wrdy = app_wdf_rdy; p_data = app_wdf_data;
   endtask

   task automatic run_pass(input string tag);
      for (int i = 0; i < 300 && !seen_done; i++) cycle();
      check({tag, "_done"}, 64'(done), 64'd1);
   endtask

   task automatic do_restart();
      restart = 1;
      cycle();
      restart = 0;
      check("restart_clr", 64'({tg_compare_error, timeout, done, err_count}), 64'd0);
   endtask

   task automatic check_clean(input string tag);
      check({tag, "_err"}, 64'({tg_compare_error, timeout}), 64'd0);
      check({tag, "_cnt"}, 64'(err_count), 64'd0);
      check({tag, "_nwr"}, 64'(nw_cmd), 64'd4);
      check({tag, "_nrd"}, 64'(nr_beat), 64'd4);
      check({tag, "_done_lat"}, 64'(cyc_done - cyc_last_beat), 64'd1);
      for (int i = 0; i < 4; i++) check({tag, "_mem"}, mem[i], pat(i));
      check({tag, "_addr0"}, 64'(waddr_log.size() > 0 ? waddr_log[0] : -1), 64'd0);
   endtask

   initial begin
      rst_n = 0; init_calib_complete = 0; app_rdy = 0; app_wdf_rdy = 0;
      app_rd_data_valid = 0; app_rd_data = '0; restart = 0;
      bp = 0; tmo_mode = 0; inj = 0; inj_done = 0; corrupt_k = -1; wtog = 0;
      start_pass();
      repeat (3) cycle();
      check("rst_req", 64'({app_en, app_wdf_wren, app_wdf_end, app_cmd}), 64'd0);
      check("rst_addr", 64'(app_addr), 64'd0);
      check("rst_data", app_wdf_data, 64'd0);
      check("rst_mask", 64'(app_wdf_mask), 64'd0);
      check("rst_stat", 64'({tg_compare_error, timeout, done, err_count}), 64'd0);
      rst_n = 1;
      repeat (2) cycle();
      check("idle_no_cal", 64'(app_en), 64'd0);

      // Clean pass, first command two cycles after calibration.
      init_calib_complete = 1;
      cycle();
      check("first_cmd_c1", 64'(app_en), 64'd0);
      cycle();
      check("first_cmd_c2", 64'({app_en, app_cmd, app_wdf_wren, app_wdf_end}), 64'b1_000_1_1);
      check("first_wdata", app_wdf_data, 64'h00000001_00000000);
      run_pass("clean");
      check_clean("clean");
      check("clean_mem2", mem[2], 64'h00000201_00000200);
      for (int i = 0; i < 4; i++) check("clean_waddr", 64'(i < waddr_log.size() ? waddr_log[i] : -1), 64'(8 * i));
      check("clean_nrcmd", 64'(nr_cmd), 64'd4);

      // Backpressure.
      start_pass(); bp = 1;
      do_restart();
      run_pass("bp");
      check_clean("bp");
      check("bp_stalls", 64'(st1), 64'd3);
      bp = 0;

      // Corrupt burst 2.
      start_pass(); corrupt_k = 2;
      do_restart();
      run_pass("corrupt");
      check("corrupt_flag", 64'(tg_compare_error), 64'd1);
      check("corrupt_cnt", 64'(err_count), 64'd1);
      check("corrupt_seen", 64'(cyc_bad >= 0), 64'd1);
      check("corrupt_done_lat", 64'(cyc_done - cyc_last_beat), 64'd1);
      corrupt_k = -1;

      // Spurious beat during WRITE.
      start_pass(); inj = 1; inj_done = 0;
      do_restart();
      run_pass("spur");
      check("spur_flag", 64'(tg_compare_error), 64'd1);
      check("spur_cnt", 64'(err_count), 64'd1);
      check("spur_nrd", 64'(nr_beat), 64'd4);
      inj = 0;

      // Calibration lost mid-READ.
      start_pass();
      do_restart();
      for (int i = 0; i < 200 && nr_cmd < 2; i++) cycle();
      check("drop_in_read", 64'(nr_cmd), 64'd2);
      init_calib_complete = 0;
      cycle();
      check("drop_idle", 64'({app_en, app_wdf_wren, done}), 64'd0);
      repeat (3) cycle();
      check("drop_hold", 64'({app_en, done}), 64'd0);
      start_pass();
      init_calib_complete = 1;
      run_pass("recal");
      check_clean("recal");

      // Watchdog.
      start_pass(); tmo_mode = 1;
      r0 = cyc;
      do_restart();
      run_pass("tmo");
      check("tmo_flags", 64'({timeout, tg_compare_error}), 64'b11);
      check("tmo_cnt", 64'(err_count), 64'd0);
      check("tmo_when", 64'(cyc_done - r0), 64'd18);
      tmo_mode = 0;
      start_pass();
      do_restart();
      run_pass("post_tmo");
      check_clean("post_tmo");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
